stopwatch_top: RTL and testbench

Four-digit FND stopwatch for the 100 MHz board top level. Counts centiseconds, seconds, minutes and hours under control of two debounced push-buttons. Time-multiplexes the selected pair of fields onto a common-anode 4-digit 7-segment display. The sw0 switch selects which pair is shown.

---
 rtl/stopwatch_top.sv | 227 ++++++++++++++++++++++
 tb/tb_stopwatch_top.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_top.sv
// Four-digit 7-segment stopwatch: debounced run/stop and clear buttons, cc/ss/mm/hh counters, multiplexed FND scan.
// Optional macro STOPWATCH_DP_BLINK_EN: blink the digit-2 decimal point at 1 Hz instead of lighting it steadily.

module stopwatch_debounce #(
   parameter int DEB_DIV = 1_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_pulse
);
   localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(DEB_DIV - 1);

   logic [1:0]    r_sync;
   logic [DW-1:0] r_div;
   logic [7:0]    r_shift;
   logic          r_level;
   logic          r_level_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync    <= '0;
         r_div     <= '0;
         r_shift   <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], i_btn};
         r_level_d <= r_level;
         if (r_div == DIV_MAX) begin
            r_div   <= '0;
            r_shift <= {r_shift[6:0], r_sync[1]};
         end else begin
            r_div <= r_div + 1'b1;
         end
         // Level only moves on a unanimous window; mixed windows hold it.
         if (&r_shift)
            r_level <= 1'b1;
         else if (~|r_shift)
            r_level <= 1'b0;
      end
   end

   assign o_pulse = r_level & ~r_level_d;
endmodule

module stopwatch_top #(
   parameter int TICK_DIV = 1_000_000,
   parameter int SCAN_DIV = 100_000,
   parameter int DEB_DIV  = 1_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sw0,
   input  logic       btnL_clear,
   input  logic       btnR_runstop,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_clear_pulse;
   logic          w_run_pulse;
   logic [1:0]    r_sw_sync;
   logic [PW-1:0] r_presc;
   logic [6:0]    r_cc;
   logic [5:0]    r_ss;
   logic [5:0]    r_mm;
   logic [4:0]    r_hh;
   logic [SW-1:0] r_scan_cnt;
   logic [1:0]    r_idx;
   logic [6:0]    w_hi;
   logic [6:0]    w_lo;
   logic [3:0]    w_digit;
   logic [7:0]    w_seg;
   logic          w_dp_on;
   logic [3:0]    r_com;
   logic [7:0]    r_data;

   stopwatch_debounce #(.DEB_DIV(DEB_DIV)) u_deb_clear (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btnL_clear),
      .o_pulse (w_clear_pulse)
   );

   stopwatch_debounce #(.DEB_DIV(DEB_DIV)) u_deb_run (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btnR_runstop),
      .o_pulse (w_run_pulse)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_STOP;
      else      r_state <= w_next;
   end

   // Run/stop is checked first so it wins over a simultaneous clear in STOP.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_STOP: begin
            if (w_run_pulse)        w_next = ST_RUN;
            else if (w_clear_pulse) w_next = ST_CLEAR;
         end
         ST_RUN:   if (w_run_pulse) w_next = ST_STOP;
         ST_CLEAR: w_next = ST_STOP;
         default:  w_next = ST_STOP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc <= '0;
         r_cc    <= '0;
         r_ss    <= '0;
         r_mm    <= '0;
         r_hh    <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_presc <= '0;
         r_cc    <= '0;
         r_ss    <= '0;
         r_mm    <= '0;
         r_hh    <= '0;
      end else if (r_state == ST_RUN) begin
         if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            if (r_cc == 7'd99) begin
               r_cc <= '0;
               if (r_ss == 6'd59) begin
                  r_ss <= '0;
                  if (r_mm == 6'd59) begin
                     r_mm <= '0;
                     r_hh <= (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
                  end else begin
                     r_mm <= r_mm + 6'd1;
                  end
               end else begin
                  r_ss <= r_ss + 6'd1;
               end
            end else begin
               r_cc <= r_cc + 7'd1;
            end
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sw_sync  <= '0;
         r_scan_cnt <= '0;
         r_idx      <= '0;
      end else begin
         r_sw_sync <= {r_sw_sync[0], sw0};
         if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      w_hi    = r_sw_sync[1] ? {2'b00, r_hh} : {1'b0, r_ss};
      w_lo    = r_sw_sync[1] ? {1'b0, r_mm}  : r_cc;
      w_digit = 4'd0;
      case (r_idx)
         2'd0: w_digit = 4'(w_lo % 7'd10);
         2'd1: w_digit = 4'(w_lo / 7'd10);
         2'd2: w_digit = 4'(w_hi % 7'd10);
         2'd3: w_digit = 4'(w_hi / 7'd10);
         default: w_digit = 4'd0;
      endcase
   end

   always_comb begin
      w_seg = 8'hC0;
      case (w_digit)
         4'd0: w_seg = 8'hC0;
         4'd1: w_seg = 8'hF9;
         4'd2: w_seg = 8'hA4;
         4'd3: w_seg = 8'hB0;
         4'd4: w_seg = 8'h99;
         4'd5: w_seg = 8'h92;
         4'd6: w_seg = 8'h82;
         4'd7: w_seg = 8'hF8;
         4'd8: w_seg = 8'h80;
         4'd9: w_seg = 8'h90;
         default: w_seg = 8'hFF;
      endcase
   end

`ifdef STOPWATCH_DP_BLINK_EN
   assign w_dp_on = (r_idx == 2'd2) && (r_cc < 7'd50);
`else
   assign w_dp_on = (r_idx == 2'd2);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_com  <= 4'b1110;
         r_data <= 8'hC0;
      end else begin
         r_com  <= ~(4'b0001 << r_idx);
         r_data <= w_dp_on ? (w_seg & 8'h7F) : w_seg;
      end
   end

   assign fnd_com  = r_com;
   assign fnd_data = r_data;
endmodule

// File: tb/tb_stopwatch_top.sv
// Directed bench for stopwatch_top with shortened dividers (TICK 10, SCAN 4, DEB 2).

module tb_stopwatch_top;
   localparam int TICK = 10;
   localparam int SCAN = 4;
   localparam int DEB  = 2;
   localparam logic [1:0] S_STOP  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;

   logic       clk;
   logic       rst;
   logic       sw0;
   logic       btnL_clear;
   logic       btnR_runstop;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int n_total;
   int n_bad;
   int run_cycles;
   int run_entries;
   int base;
   logic [1:0] st;
   logic [1:0] st_prev;

   stopwatch_top #(.TICK_DIV(TICK), .SCAN_DIV(SCAN), .DEB_DIV(DEB)) dut (
      .clk          (clk),
      .rst          (rst),
      .sw0          (sw0),
      .btnL_clear   (btnL_clear),
      .btnR_runstop (btnR_runstop),
      .fnd_com      (fnd_com),
      .fnd_data     (fnd_data)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign st = dut.r_state;

   // Reference time model: every negedge seen in RUN is one prescaler step at the next edge.
   initial begin
      run_cycles  = 0;
      run_entries = 0;
      st_prev     = S_STOP;
      forever begin
         @(negedge clk);
         if (rst && st == S_RUN) run_cycles++;
         if (rst && st == S_RUN && st_prev != S_RUN) run_entries++;
         st_prev = st;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clocks(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic press(input bit is_run, input int hi, input int lo);
      if (is_run) btnR_runstop = 1'b1; else btnL_clear = 1'b1;
      clocks(hi);
      btnR_runstop = 1'b0;
      btnL_clear   = 1'b0;
      clocks(lo);
   endtask

   task automatic wait_state(input string tag, input logic [1:0] want, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (st == want) break;
         @(negedge clk);
      end
      check_eq(tag, 32'(st), 32'(want));
   endtask

   task automatic check_digit(input string tag, input int idx, input logic [7:0] exp);
      logic [3:0] com_exp;
      com_exp = ~(4'b0001 << idx);
      for (int i = 0; i < 40; i++) begin
         if (fnd_com == com_exp) break;
         @(negedge clk);
      end
      check_eq({tag, "_com"}, 32'(fnd_com), 32'(com_exp));
      check_eq(tag, 32'(fnd_data), 32'(exp));
   endtask

   task automatic check_model(input string tag);
      int t;
      t = run_cycles - base;
      check_eq({tag, "_cc"}, 32'(dut.r_cc), 32'((t / TICK) % 100));
      check_eq({tag, "_ss"}, 32'(dut.r_ss), 32'((t / (TICK * 100)) % 60));
      check_eq({tag, "_presc"}, 32'(dut.r_presc), 32'(t % TICK));
   endtask

   initial begin
      int e0;
      n_total = 0;
      n_bad   = 0;
      base    = 0;
      sw0          = 1'b0;
      btnL_clear   = 1'b0;
      btnR_runstop = 1'b0;
      rst          = 1'b0;

      // reset
      #50;
      check_eq("rst_com", 32'(fnd_com), 32'h0E);
      check_eq("rst_data", 32'(fnd_data), 32'hC0);
      #50;
      @(negedge clk);
      rst = 1'b1;
      clocks(5);
      check_eq("rst_state", 32'(st), 32'(S_STOP));
      check_eq("rst_cc", 32'(dut.r_cc), 32'd0);

      // start: first RUN entry, then 1000 edges -> 1.00 s
      btnR_runstop = 1'b1;
      wait_state("start_run", S_RUN, 100);
      for (int i = 0; i < 1000; i++) @(posedge clk);
      @(negedge clk);
      check_eq("start_ss", 32'(dut.r_ss), 32'd1);
      check_eq("start_cc", 32'(dut.r_cc), 32'd0);
      check_digit("start_ss_ones_digit", 2, 8'h79);
      check_digit("start_ss_tens_digit", 3, 8'hC0);
      btnR_runstop = 1'b0;
      clocks(40);
      check_eq("start_entries", 32'(run_entries), 32'd1);

      // stop, freeze, resume, stop
      press(1'b1, 40, 40);
      wait_state("stop_state", S_STOP, 10);
      clocks(5000);
      check_model("frozen");
      press(1'b1, 40, 40);
      wait_state("resume_state", S_RUN, 10);
      clocks(333);
      press(1'b1, 40, 40);
      wait_state("stop2_state", S_STOP, 10);
      check_model("resumed");

      // clear ignored in RUN, honoured in STOP
      press(1'b1, 40, 40);
      press(1'b0, 40, 40);
      check_eq("clear_in_run_state", 32'(st), 32'(S_RUN));
      press(1'b1, 40, 40);
      wait_state("stop3_state", S_STOP, 10);
      check_model("clear_in_run");
      press(1'b0, 40, 40);
      check_eq("clear_state", 32'(st), 32'(S_STOP));
      check_eq("clear_cc", 32'(dut.r_cc), 32'd0);
      check_eq("clear_ss", 32'(dut.r_ss), 32'd0);
      check_eq("clear_presc", 32'(dut.r_presc), 32'd0);
      base = run_cycles;
      check_digit("clear_d0", 0, 8'hC0);
      check_digit("clear_d1", 1, 8'hC0);
      check_digit("clear_d2", 2, 8'h40);
      check_digit("clear_d3", 3, 8'hC0);

      // bounce: only the stable hold may count as a press
      e0 = run_entries;
      for (int i = 0; i < 40; i++) begin
         if (i % 3 == 0) btnR_runstop = ~btnR_runstop;
         @(negedge clk);
      end
      check_eq("bounce_no_toggle", 32'(st), 32'(S_STOP));
      btnR_runstop = 1'b1;
      clocks(60);
      btnR_runstop = 1'b0;
      clocks(60);
      check_eq("bounce_state", 32'(st), 32'(S_RUN));
      check_eq("bounce_entries", 32'(run_entries), 32'(e0 + 1));
      press(1'b1, 40, 40);
      wait_state("bounce_stop", S_STOP, 10);

      // wrap 23:59:59.99 -> 00:00:00.00
      force dut.r_hh = 5'd23;
      force dut.r_mm = 6'd59;
      force dut.r_ss = 6'd59;
      force dut.r_cc = 7'd99;
      force dut.r_presc = '0;
      @(negedge clk);
      release dut.r_hh;
      release dut.r_mm;
      release dut.r_ss;
      release dut.r_cc;
      release dut.r_presc;
      @(negedge clk);
      check_eq("preload_hh", 32'(dut.r_hh), 32'd23);
      btnR_runstop = 1'b1;
      wait_state("wrap_run", S_RUN, 100);
      for (int i = 0; i < TICK; i++) @(posedge clk);
      @(negedge clk);
      check_eq("wrap_hh", 32'(dut.r_hh), 32'd0);
      check_eq("wrap_mm", 32'(dut.r_mm), 32'd0);
      check_eq("wrap_ss", 32'(dut.r_ss), 32'd0);
      check_eq("wrap_cc", 32'(dut.r_cc), 32'd0);
      btnR_runstop = 1'b0;
      clocks(40);
      press(1'b1, 40, 40);
      wait_state("wrap_stop", S_STOP, 10);
      sw0 = 1'b1;
      clocks(10);
      check_digit("hhmm_d0", 0, 8'hC0);
      check_digit("hhmm_d1", 1, 8'hC0);
      check_digit("hhmm_d2", 2, 8'h40);
      check_digit("hhmm_d3", 3, 8'hC0);

      // reset mid-count
      sw0 = 1'b0;
      press(1'b1, 40, 40);
      wait_state("midrst_run", S_RUN, 10);
      clocks(50);
      rst = 1'b0;
      #2;
      check_eq("midrst_state", 32'(st), 32'(S_STOP));
      check_eq("midrst_cc", 32'(dut.r_cc), 32'd0);
      check_eq("midrst_com", 32'(fnd_com), 32'h0E);
      check_eq("midrst_data", 32'(fnd_data), 32'hC0);
      clocks(3);
      rst = 1'b1;
      clocks(3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
